// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: state and owner encodings, latency range constants and the helper
// that turns a configured latency into the WAIT down-counter load value.
// Ports: none (package).

package mem_arb_pkg;

  // Arbiter sequencing states; encoding is fixed so traces read the same
  // across every instance.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_e;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    OWNER_IF   = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 15;
  localparam int CNT_WIDTH = 4;

  // WAIT lasts exactly `lat` cycles, so the counter starts at lat-1 and the
  // read data is captured in the cycle it shows zero. Out-of-range latencies
  // are clamped so the 4-bit counter can never wrap.
  function automatic logic [CNT_WIDTH-1:0] latLoadValue(input int lat);
    int clamped;
    if (lat < LAT_MIN) begin
      clamped = LAT_MIN;
    end else if (lat > LAT_MAX) begin
      clamped = LAT_MAX;
    end else begin
      clamped = lat;
    end
    return CNT_WIDTH'(clamped - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between pipeline, arbiter and RAM
//
// Purpose: groups the fetch port, the data port and the RAM port of the
// memory port arbiter into one interface.
// Modports:
//   slave  - the arbiter: takes requests and ram_rdata, drives done/rdata,
//            stalls and the RAM strobe/address/write data.
//   master - the pipeline and RAM side: the mirror image of slave.
// Signals:
//   if_req/if_addr/if_cancel -> if_done/if_rdata/stall_if     (fetch port)
//   mem_read/mem_write/mem_addr/mem_wdata
//                            -> mem_done/mem_rdata/stall_mem (data port)
//   ram_en/ram_we/ram_addr/ram_wdata <- ram_rdata             (RAM port)

interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_cancel;
  logic                  if_done;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  stall_if;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_done;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  stall_mem;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, if_cancel,
    output if_done, if_rdata, stall_if,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_done, mem_rdata, stall_mem,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr, if_cancel,
    input  if_done, if_rdata, stall_if,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_done, mem_rdata, stall_mem,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - loadable 4-bit down-counter with zero flag
//
// Purpose: times the RAM read latency for the arbiter's WAIT state.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset (count -> 0)
//   load          - load loadValue this cycle (wins over dec)
//   loadValue     - value to load
//   dec           - decrement by one; saturates at zero
//   count         - current count
//   zero          - count == 0

module mem_lat_counter
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] loadValue,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a shared single-port RAM
//
// Purpose: serialises instruction fetches and loads/stores onto one
// fixed-latency RAM. MEM wins arbitration (older instruction). Each access
// runs IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> DONE -> IDLE, giving a
// request-to-done latency of MEM_LATENCY+2 cycles.
// Parameters: ADDR_WIDTH, DATA_WIDTH, MEM_LATENCY (1..15).
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset; abandons any access in flight
//   bus    - mem_port_arbiter_if.slave: fetch port, data port, RAM port,
//            done pulses, held read data and stall requests

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAT_LOAD = latLoadValue(MEM_LATENCY);

  arbState_e state;
  arbState_e stateNext;
  owner_e    owner;
  logic      accWrite;
  logic      discard;

  logic                  ramEnQ;
  logic                  ramWeQ;
  logic [ADDR_WIDTH-1:0] ramAddrQ;
  logic [DATA_WIDTH-1:0] ramWdataQ;
  logic [DATA_WIDTH-1:0] ifRdataQ;
  logic [DATA_WIDTH-1:0] memRdataQ;

  logic                 dataReq;
  logic                 anyReq;
  logic                 grant;
  logic                 capture;
  logic                 cntLoad;
  logic                 cntDec;
  logic                 cntZero;
  logic [CNT_WIDTH-1:0] cntValue;
  logic                 ifDone;
  logic                 memDone;

  // A simultaneous read+write is treated as a write (mem_write decides).
  assign dataReq = bus.mem_read | bus.mem_write;
  assign anyReq  = dataReq | bus.if_req;
  assign grant   = (state == IDLE) && anyReq;
  // ram_rdata is valid in the last WAIT cycle, when the counter shows zero.
  assign capture = (state == WAIT) && cntZero;

  mem_lat_counter uLatCounter (
    .clk       (clk),
    .reset     (reset),
    .load      (cntLoad),
    .loadValue (LAT_LOAD),
    .dec       (cntDec),
    .count     (cntValue),
    .zero      (cntZero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    ifDone    = 1'b0;
    memDone   = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        cntLoad   = 1'b1;
        stateNext = WAIT;
      end
      WAIT: begin
        if (cntZero) begin
          stateNext = DONE;
        end else begin
          cntDec = 1'b1;
        end
      end
      DONE: begin
        // Requests are not sampled here, so a requester still holding its
        // request during its own done cycle is not served twice.
        memDone   = (owner == OWNER_DATA);
        ifDone    = (owner == OWNER_IF) && !discard && !bus.if_cancel;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Access registers: owner, RAM strobe/address/data and returned data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWNER_IF;
      accWrite  <= 1'b0;
      ramEnQ    <= 1'b0;
      ramWeQ    <= 1'b0;
      ramAddrQ  <= '0;
      ramWdataQ <= '0;
      ifRdataQ  <= '0;
      memRdataQ <= '0;
    end else begin
      // ram_en/ram_we are high only for the single ISSUE cycle.
      ramEnQ <= grant;
      ramWeQ <= grant && dataReq && bus.mem_write;
      if (grant) begin
        if (dataReq) begin
          owner     <= OWNER_DATA;
          accWrite  <= bus.mem_write;
          ramAddrQ  <= bus.mem_addr;
          ramWdataQ <= bus.mem_wdata;
        end else begin
          // Fetches leave ram_wdata at its last value.
          owner    <= OWNER_IF;
          accWrite <= 1'b0;
          ramAddrQ <= bus.if_addr;
        end
      end
      if (capture) begin
        if ((owner == OWNER_DATA) && !accWrite) begin
          memRdataQ <= bus.ram_rdata;
        end
        if ((owner == OWNER_IF) && !discard && !bus.if_cancel) begin
          ifRdataQ <= bus.ram_rdata;
        end
      end
    end
  end

  // A branch redirect during an in-flight fetch poisons that fetch; the
  // sequence still runs to completion so the RAM timing is undisturbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard <= 1'b0;
    end else if (state == DONE) begin
      discard <= 1'b0;
    end else if (bus.if_cancel && (owner == OWNER_IF) &&
                 ((state == ISSUE) || (state == WAIT))) begin
      discard <= 1'b1;
    end
  end

  assign bus.ram_en    = ramEnQ;
  assign bus.ram_we    = ramWeQ;
  assign bus.ram_addr  = ramAddrQ;
  assign bus.ram_wdata = ramWdataQ;
  assign bus.if_rdata  = ifRdataQ;
  assign bus.mem_rdata = memRdataQ;
  assign bus.if_done   = ifDone;
  assign bus.mem_done  = memDone;

  // stall_mem also freezes every earlier stage, so it folds into stall_if.
  assign bus.stall_mem = dataReq && !memDone;
  assign bus.stall_if  = (bus.if_req && !ifDone) || bus.stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b2 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b1 ();

  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_LATENCY(2)) dut2 (
    .clk(clk), .reset(rst), .bus(b2));
  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst), .bus(b1));

  // RAM models: rdata valid MEM_LATENCY cycles after ram_en, 0xEE otherwise.
  logic [7:0] ram2 [256];
  logic [7:0] ram1 [256];
  logic [7:0] pipe2 [2];
  logic [7:0] pipe1;

  always @(posedge clk) begin
    if (rst) begin
      ram2[8'h10] <= 8'hA5;
      ram2[8'h30] <= 8'h5A;
      ram2[8'h44] <= 8'h77;
    end else if (b2.ram_en && b2.ram_we) begin
      ram2[b2.ram_addr] <= b2.ram_wdata;
    end
    pipe2[0] <= b2.ram_en ? ram2[b2.ram_addr] : 8'hEE;
    pipe2[1] <= pipe2[0];
  end
  assign b2.ram_rdata = pipe2[1];

  always @(posedge clk) begin
    if (rst) begin
      ram1[8'h00] <= 8'h11;
      ram1[8'h01] <= 8'h22;
    end
    pipe1 <= b1.ram_en ? ram1[b1.ram_addr] : 8'hEE;
  end
  assign b1.ram_rdata = pipe1;

  typedef struct {
    bit       isData;
    logic [7:0] data;
    int       cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  function automatic exp_t mk(input bit d, input logic [7:0] v, input int cy);
    exp_t e;
    e.isData = d;
    e.data   = v;
    e.cyc    = cy;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every done pulse pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (b2.if_done || b2.mem_done)) begin
      if (q2.size() == 0) begin
        chk("dut2 unexpected done", cyc, -1);
      end else begin
        e = q2.pop_front();
        chk("dut2 done kind", int'(b2.mem_done), int'(e.isData));
        chk("dut2 done cycle", cyc, e.cyc);
        chk("dut2 rdata", e.isData ? b2.mem_rdata : b2.if_rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (b1.if_done || b1.mem_done)) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected done", cyc, -1);
      end else begin
        e = q1.pop_front();
        chk("dut1 done kind", int'(b1.mem_done), int'(e.isData));
        chk("dut1 done cycle", cyc, e.cyc);
        chk("dut1 rdata", e.isData ? b1.mem_rdata : b1.if_rdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    b2.if_req = 0; b2.if_addr = 0; b2.if_cancel = 0;
    b2.mem_read = 0; b2.mem_write = 0; b2.mem_addr = 0; b2.mem_wdata = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.if_cancel = 0;
    b1.mem_read = 0; b1.mem_write = 0; b1.mem_addr = 0; b1.mem_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ram_en", b2.ram_en, 0);
    chk("reset ram_we", b2.ram_we, 0);
    chk("reset ram_addr", b2.ram_addr, 0);
    chk("reset ram_wdata", b2.ram_wdata, 0);
    chk("reset if_done", b2.if_done, 0);
    chk("reset mem_done", b2.mem_done, 0);
    chk("reset if_rdata", b2.if_rdata, 0);
    chk("reset mem_rdata", b2.mem_rdata, 0);
    chk("reset stall_if", b2.stall_if, 0);
    chk("reset stall_mem", b2.stall_mem, 0);
    rst = 0;
    tick();

    // 1. Fetch of 0x10 -> 0xA5, done 4 cycles later.
    c = cyc;
    b2.if_req = 1; b2.if_addr = 8'h10;
    q2.push_back(mk(0, 8'hA5, c + 4));
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("t1 stall_if", b2.stall_if, int'(k < 4));
      if (k == 1) begin
        chk("t1 ram_en", b2.ram_en, 1);
        chk("t1 ram_addr", b2.ram_addr, 8'h10);
        chk("t1 ram_we", b2.ram_we, 0);
      end
      if (k == 2) chk("t1 ram_en after issue", b2.ram_en, 0);
      tick();
    end
    b2.if_req = 0;
    tick();

    // 2. Store 0x3C to 0x21, then load it back.
    c = cyc;
    b2.mem_write = 1; b2.mem_addr = 8'h21; b2.mem_wdata = 8'h3C;
    q2.push_back(mk(1, 8'h00, c + 4));
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("t2 stall_mem", b2.stall_mem, int'(k < 4));
      if (k == 1) begin
        chk("t2 ram_we", b2.ram_we, 1);
        chk("t2 ram_addr", b2.ram_addr, 8'h21);
        chk("t2 ram_wdata", b2.ram_wdata, 8'h3C);
      end
      tick();
    end
    b2.mem_write = 0;
    c = cyc;
    b2.mem_read = 1;
    q2.push_back(mk(1, 8'h3C, c + 4));
    repeat (5) tick();
    b2.mem_read = 0;
    tick();

    // 3. Simultaneous fetch and load: data first, fetch issues in cycle 6.
    c = cyc;
    b2.if_req = 1; b2.if_addr = 8'h10;
    b2.mem_read = 1; b2.mem_addr = 8'h21;
    q2.push_back(mk(1, 8'h3C, c + 4));
    q2.push_back(mk(0, 8'hA5, c + 9));
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      chk("t3 stall_if", b2.stall_if, int'(k <= 8));
      if (k == 1) begin
        chk("t3 data ram_en", b2.ram_en, 1);
        chk("t3 data ram_addr", b2.ram_addr, 8'h21);
      end
      if (k == 6) begin
        chk("t3 fetch ram_en", b2.ram_en, 1);
        chk("t3 fetch ram_addr", b2.ram_addr, 8'h10);
      end
      tick();
      if (k == 4) b2.mem_read = 0;
    end
    b2.if_req = 0;
    tick();

    // 4. Cancelled fetch: no done, if_rdata held, next fetch served from cycle 5.
    c = cyc;
    b2.if_req = 1; b2.if_addr = 8'h30;
    tick();
    tick();
    b2.if_cancel = 1; b2.if_req = 0;
    tick();
    b2.if_cancel = 0;
    tick();
    @(negedge clk);
    chk("t4 if_done suppressed", b2.if_done, 0);
    chk("t4 if_rdata held", b2.if_rdata, 8'hA5);
    tick();
    c = cyc;
    b2.if_req = 1; b2.if_addr = 8'h44;
    q2.push_back(mk(0, 8'h77, c + 4));
    repeat (5) tick();
    b2.if_req = 0;
    tick();

    // 5. Reset during a load; the re-issued load completes normally.
    b2.mem_read = 1; b2.mem_addr = 8'h30;
    tick();
    tick();
    #2 rst = 1;
    #1;
    chk("t5 async ram_addr", b2.ram_addr, 0);
    chk("t5 async mem_rdata", b2.mem_rdata, 0);
    chk("t5 async if_rdata", b2.if_rdata, 0);
    chk("t5 async ram_en", b2.ram_en, 0);
    chk("t5 async mem_done", b2.mem_done, 0);
    @(posedge clk);
    #1;
    rst = 0;
    c = cyc;
    q2.push_back(mk(1, 8'h5A, c + 4));
    repeat (5) tick();
    b2.mem_read = 0;
    tick();

    // 6. MEM_LATENCY=1: back-to-back fetches of 0x00 and 0x01.
    c = cyc;
    b1.if_req = 1; b1.if_addr = 8'h00;
    q1.push_back(mk(0, 8'h11, c + 3));
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("t6 first ram_en", b1.ram_en, 1);
        chk("t6 first ram_addr", b1.ram_addr, 8'h00);
      end
      if (k == 5) begin
        chk("t6 second ram_en", b1.ram_en, 1);
        chk("t6 second ram_addr", b1.ram_addr, 8'h01);
      end
      tick();
      if (k == 3) begin
        b1.if_addr = 8'h01;
        q1.push_back(mk(0, 8'h22, c + 7));
      end
    end
    b1.if_req = 0;

    repeat (3) tick();
    chk("dut2 responses outstanding", q2.size(), 0);
    chk("dut1 responses outstanding", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
